// File: rtl/button_event.sv
// button_event: press/release/hold/auto-repeat pulse generator for a clean button level
module button_event #(
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic       press,
  output logic       rel,
  output logic       hold,
  output logic       rpt,
  output logic       held,
  output logic [7:0] press_count
);
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
  localparam logic [15:0] HT = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] RT = 16'(REPEAT_CYCLES - 1);
  state_t      state;
  logic [15:0] cnt;
  logic        in_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      in_q        <= 1'b0;
      press       <= 1'b0;
      rel         <= 1'b0;
      hold        <= 1'b0;
      rpt         <= 1'b0;
      held        <= 1'b0;
      press_count <= '0;
    end else begin
      in_q  <= in;
      press <= 1'b0;
      rel   <= 1'b0;
      hold  <= 1'b0;
      rpt   <= 1'b0;
      case (state)
        IDLE: if (in_q) begin
          state       <= PRESSED;
          cnt         <= '0;
          press       <= 1'b1;
          press_count <= press_count + 8'd1;
        end
        PRESSED: if (!in_q) begin
          state <= IDLE;
          cnt   <= '0;
          rel   <= 1'b1;
        end else if (cnt == HT) begin
          state <= HELD;
          cnt   <= '0;
          hold  <= 1'b1;
          held  <= 1'b1;
        end else cnt <= cnt + 16'd1;
        HELD: if (!in_q) begin
          state <= IDLE;
          cnt   <= '0;
          rel   <= 1'b1;
          held  <= 1'b0;
        end else if (cnt == RT) begin
          cnt <= '0;
          rpt <= 1'b1;
        end else cnt <= cnt + 16'd1;
        default: begin
          state <= IDLE;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: random presses checked against a cycle-timing model of the button events
module tb_button_event;
  localparam int H = 8;
  localparam int R = 4;
  logic clk = 0, rst = 1, in = 0;
  logic press, rel, hold, rpt, held;
  logic [7:0] press_count;
  int total = 0, passed = 0, n_press = 0, n_rel = 0;
  bit q, act, e_press, e_rel, e_hold, e_rpt, e_held;
  int d;
  logic [7:0] e_cnt;
  button_event #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .in(in), .press(press), .rel(rel), .hold(hold),
    .rpt(rpt), .held(held), .press_count(press_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    else passed++;
  endtask
  // d counts cycles since the press pulse; hold/repeat fall out of that age directly
  always @(posedge clk) begin
    if (rst) begin
      q = 0; act = 0; d = 0; e_cnt = 0;
      {e_press, e_rel, e_hold, e_rpt, e_held} = '0;
    end else begin
      {e_press, e_rel, e_hold, e_rpt} = '0;
      if (!act && q) begin
        act = 1; d = 0; e_press = 1; e_cnt++;
      end else if (act && !q) begin
        act = 0; e_rel = 1;
      end else if (act) begin
        d++;
        e_hold = (d == H);
        e_rpt  = (d > H) && ((d - H) % R == 0);
      end
      e_held = act && (d >= H);
      q = in;
    end
  end
  always @(negedge clk) begin
    chk("press", press, e_press);
    chk("release", rel, e_rel);
    chk("hold", hold, e_hold);
    chk("repeat", rpt, e_rpt);
    chk("held", held, e_held);
    chk("press_count", press_count, e_cnt);
    chk("one_hot", (press + rel + hold + rpt) > 1, 0);
    if (press) n_press++;
    if (rel) n_rel++;
  end
  task automatic hi(input int n, input int gap);
    in = 1;
    repeat (n) @(negedge clk);
    in = 0;
    repeat (gap) @(negedge clk);
  endtask
  task automatic pulse_rst();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    int p0, r0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    hi(3, 6);
    chk("short_count", press_count, 1);
    hi(30, 6);
    hi(8, 6);
    hi(9, 6);
    in = 1;
    repeat (12) @(negedge clk);
    pulse_rst();
    repeat (6) @(negedge clk);
    in = 0;
    repeat (4) @(negedge clk);
    chk("rst_mid_held_count", press_count, 1);
    pulse_rst();
    @(negedge clk);
    p0 = n_press; r0 = n_rel;
    for (int i = 0; i < 257; i++) hi($urandom_range(1, 3), $urandom_range(1, 3));
    repeat (3) @(negedge clk);
    @(posedge clk);
    chk("wrap_count", press_count, 1);
    chk("wrap_presses", 16'(n_press - p0), 257);
    chk("wrap_releases", 16'(n_rel - r0), 257);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) pulse_rst();
      hi($urandom_range(1, 30), $urandom_range(1, 5));
    end
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000: cycles from the press pulse to the hold pulse; legal range 2..65535.
REQ-002 Parameter REPEAT_CYCLES, default 200: cycles between auto-repeat pulses while held; legal range 2..65535.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 in  input  1  debounced button level, 1 = pressed; asynchronous to no one (already clean, same clock domain).
REQ-006 press  output  1  one-cycle pulse on each press.
REQ-007 release  output  1  one-cycle pulse on each release.
REQ-008 hold  output  1  one-cycle pulse when a press has lasted HOLD_CYCLES.
REQ-009 repeat  output  1  one-cycle auto-repeat pulse while held.
REQ-010 held  output  1  level, high while the FSM is in HELD.
REQ-011 press_count  output  8  number of press pulses since reset, wrapping modulo 256.

Function
REQ-012 Register in into in_q on every posedge clk; the FSM uses only in_q, never raw in.
REQ-013 The FSM SHALL have exactly three states: IDLE, PRESSED and HELD.
REQ-014 Use one 16-bit counter cnt, cleared on every state change.
REQ-015 IDLE, in_q=1: go to PRESSED and assert press for one cycle; otherwise stay.
REQ-016 PRESSED, in_q=0: go to IDLE and assert release for one cycle.
REQ-017 PRESSED, in_q=1, cnt=HOLD_CYCLES-1: go to HELD and assert hold for one cycle; otherwise cnt+1.
REQ-018 HELD, in_q=0: go to IDLE, assert release for one cycle, and deassert held.
REQ-019 HELD, in_q=1, cnt=REPEAT_CYCLES-1: assert repeat for one cycle and clear cnt; otherwise cnt+1.
REQ-020 All outputs are registered, with no combinational path from in to any output.
REQ-021 Latency: press (or release) is high in the 2nd cycle after the first clock edge at which in is sampled high (or low).
REQ-022 If press is high in cycle P and in stays high, hold SHALL be high in cycle P+HOLD_CYCLES.
REQ-023 repeat SHALL be high in cycle P+HOLD_CYCLES+n*REPEAT_CYCLES, n>=1.
REQ-024 held is high from cycle P+HOLD_CYCLES up to and including the cycle before release.
REQ-025 At most one of press/release/hold/repeat is high in any cycle.
REQ-026 Release during the hold-terminal cycle: release wins, no hold pulse, FSM returns to IDLE.
REQ-027 Release during the repeat-terminal cycle: release wins and repeat is suppressed.
REQ-028 press_count increments in the same cycle press is high; 255 wraps to 0 with no flag.
REQ-029 A one-cycle in=1 glitch SHALL still produce exactly one press pulse followed by one release pulse.

Reset
REQ-030 On rst=1 at a posedge clk: state=IDLE, cnt=0, in_q=0, press_count=0, and press, release, hold, repeat and held are all 0.
REQ-031 rst has priority over all other activity, including mid-PRESSED or mid-HELD; no pulse is emitted in the reset cycle.
REQ-032 If in is high when rst deasserts, a fresh press pulse SHALL occur 2 cycles after deassertion.

Verification (bench: HOLD_CYCLES=8, REPEAT_CYCLES=4)
REQ-033 Short press: in high for 3 cycles, then low.
  -> press x1, then release x1 three cycles later; no hold; press_count=1.
REQ-034 Long press: in high for 25 cycles after press at cycle P.
  -> hold at P+8; repeat at P+12, P+16, P+20, P+24; held high P+8..release-1; release x1.
REQ-035 Release on the terminal: in falls so that in_q=0 in the cycle cnt=7 in PRESSED.
  -> release only, no hold, held stays 0.
REQ-036 Reset mid-HELD: assert rst for 1 cycle at P+10 with in still high.
  -> all outputs 0 in the reset cycle; new press 2 cycles after deassertion; press_count=1.
REQ-037 Wrap: issue 257 short presses.
  -> press_count=1 at the end, with exactly 257 press and 257 release pulses.
REQ-038 Glitch: in high for exactly 1 cycle.
  -> press in one cycle, release in the next cycle; both are one cycle wide and never overlap.
